// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle for the sequential multiply/divide unit.
// The master drives operands and start; the slave reports status and results.
interface muldiv_if #(
   parameter int W = 16
);
   logic         start;
   logic [3:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] d;
   logic         c2inA;
   logic         c2inB;
   logic         c2out;
   logic         busy;
   logic         done;
   logic         err;
   logic [W-1:0] res_hi;
   logic [W-1:0] res_lo;

   modport master (
      output start, op, a, b, d, c2inA, c2inB, c2out,
      input  busy, done, err, res_hi, res_lo
   );

   modport slave (
      input  start, op, a, b, d, c2inA, c2inB, c2out,
      output busy, done, err, res_hi, res_lo
   );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: shift-add multiply / restoring divide / negate, one bit per
// clock on complemented magnitudes, with sign correction in a final cycle.
module muldiv_seq #(
   parameter int W = 16
) (
   input  logic    clk,
   input  logic    rst_n,
   muldiv_if.slave bus
);
   localparam int H  = W / 2;
   localparam int CW = $clog2(W + 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t         state, state_nx;
   logic [3:0]     op_q;
   logic           c2a_q, c2o_q, bad_q;
   logic [CW-1:0]  cnt;
   logic [2*W-1:0] acc;
   logic [W-1:0]   opb;
   logic           done_q, err_q;
   logic [W-1:0]   hi_q, lo_q;

   logic           half, half_in, ovf_in, bad_in;
   logic [H-1:0]   ah, bh;
   logic [W-1:0]   a_neg, b_mag;
   logic [2*W-1:0] dvd, step, prod;
   logic [W:0]     add_f;
   logic [H:0]     add_h;
   logic [W+1:0]   sub_f;
   logic [H+1:0]   sub_h;
   logic [W-1:0]   qv, rv, lim_f, fix_hi, fix_lo;
   logic [H-1:0]   lim_h;
   logic           sovf, fix_err;

   assign half = ~op_q[0];

   // operand conditioning and early-exit detection at capture
   always_comb begin
      half_in = ~bus.op[0];
      ah      = bus.c2inA ? ~bus.a[H-1:0] + 1'b1 : bus.a[H-1:0];
      bh      = bus.c2inB ? ~bus.b[H-1:0] + 1'b1 : bus.b[H-1:0];
      a_neg   = bus.c2inA ? ~bus.a + 1'b1 : bus.a;
      if (half_in) begin
         dvd   = {{W{1'b0}}, a_neg};
         b_mag = {{H{1'b0}}, bh};
         ovf_in = dvd[W-1:H] >= bh;
      end else begin
         dvd   = bus.c2inA ? ~{bus.d, bus.a} + 1'b1 : {bus.d, bus.a};
         b_mag = bus.c2inB ? ~bus.b + 1'b1 : bus.b;
         ovf_in = dvd[2*W-1:W] >= b_mag;
      end
      bad_in = (bus.op[3:2] == 2'b11) ||
               ((bus.op[3:2] == 2'b01) && ((b_mag == '0) || ovf_in));
   end

   // one multiply or divide iteration on the working register
   always_comb begin
      add_f = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opb} : '0);
      add_h = {1'b0, acc[W-1:H]} + (acc[0] ? {1'b0, opb[H-1:0]} : '0);
      sub_f = {1'b0, acc[2*W-1:W-1]} - {2'b0, opb};
      sub_h = {1'b0, acc[W-1:H-1]} - {2'b0, opb[H-1:0]};
      if (op_q[2]) begin
         if (half)
            step = sub_h[H+1] ? {{W{1'b0}}, acc[W-2:0], 1'b0}
                              : {{W{1'b0}}, sub_h[H-1:0], acc[H-2:0], 1'b1};
         else
            step = sub_f[W+1] ? {acc[2*W-2:0], 1'b0}
                              : {sub_f[W-1:0], acc[W-2:0], 1'b1};
      end else begin
         if (half)
            step = {{W{1'b0}}, add_h, acc[H-1:1]};
         else
            step = {add_f, acc[W-1:1]};
      end
   end

   // result formatting, sign correction and signed-quotient range check
   always_comb begin
      prod    = '0;
      qv      = '0;
      rv      = '0;
      sovf    = 1'b0;
      fix_err = bad_q;
      fix_hi  = '0;
      fix_lo  = '0;
      lim_h   = c2o_q ? {1'b1, {(H-1){1'b0}}} : {1'b0, {(H-1){1'b1}}};
      lim_f   = c2o_q ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      unique case (op_q[3:2])
         2'b00: begin
            prod = half ? {{W{1'b0}}, acc[W-1:0]} : acc;
            if (c2o_q)
               prod = half ? {{W{1'b0}}, ~acc[W-1:0] + 1'b1} : ~acc + 1'b1;
            {fix_hi, fix_lo} = prod;
         end
         2'b01: begin
            if (half) begin
               qv = {{H{1'b0}}, c2o_q ? ~acc[H-1:0] + 1'b1 : acc[H-1:0]};
               rv = {{H{1'b0}}, c2a_q ? ~acc[W-1:H] + 1'b1 : acc[W-1:H]};
               sovf = op_q[1] && (acc[H-1:0] > lim_h);
            end else begin
               qv = c2o_q ? ~acc[W-1:0] + 1'b1 : acc[W-1:0];
               rv = c2a_q ? ~acc[2*W-1:W] + 1'b1 : acc[2*W-1:W];
               sovf = op_q[1] && (acc[W-1:0] > lim_f);
            end
            fix_err = bad_q || sovf;
            fix_hi  = rv;
            fix_lo  = qv;
         end
         2'b10: fix_lo = acc[W-1:0];
         default: fix_err = 1'b1;
      endcase
      if (fix_err) begin
         fix_hi = '0;
         fix_lo = '0;
      end
   end

   // next-state selection
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (bus.start) state_nx = (bus.op[3] || bad_in) ? FIX : RUN;
         RUN:  if (cnt == CW'(1)) state_nx = FIX;
         FIX:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // capture, iterate and publish results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q   <= '0;
         c2a_q  <= 1'b0;
         c2o_q  <= 1'b0;
         bad_q  <= 1'b0;
         cnt    <= '0;
         acc    <= '0;
         opb    <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: if (bus.start) begin
               op_q  <= bus.op;
               c2a_q <= bus.c2inA;
               c2o_q <= bus.c2out;
               bad_q <= bad_in;
               cnt   <= half_in ? CW'(H) : CW'(W);
               opb   <= bus.op[2] ? b_mag
                      : (half_in ? {{H{1'b0}}, ah} : a_neg);
               acc   <= bus.op[2] ? dvd
                      : (bus.op[3] ? {{W{1'b0}}, a_neg}
                                   : {{W{1'b0}}, b_mag});
            end
            RUN: begin
               acc <= step;
               cnt <= cnt - 1'b1;
            end
            FIX: begin
               done_q <= 1'b1;
               err_q  <= fix_err;
               hi_q   <= fix_hi;
               lo_q   <= fix_lo;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy   = (state != IDLE);
   assign bus.done   = done_q;
   assign bus.err    = err_q;
   assign bus.res_hi = hi_q;
   assign bus.res_lo = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq; an arithmetic reference
// model predicts each result and its done latency.
module tb_muldiv_seq;
   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   muldiv_if #(.W(16)) bus ();

   muldiv_seq #(.W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      string       nm;
      logic        err;
      logic [15:0] hi;
      logic [15:0] lo;
      int          lat;
      int          k;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   checks   = 0;
   int   errors   = 0;
   int   cyc      = 0;
   int   done_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, want);
      end
   endtask

   function automatic exp_t model(input string nm, input logic [3:0] op,
                                  input logic [15:0] a, input logic [15:0] b,
                                  input logic [15:0] d, input logic ca,
                                  input logic cb, input logic co);
      exp_t   e;
      longint n, mn, m2, x, y, p, q, r, qs;
      n  = op[0] ? 16 : 8;
      mn = (longint'(1) << n) - 1;
      m2 = (longint'(1) << (2 * n)) - 1;
      e.nm = nm; e.err = 1'b0; e.hi = '0; e.lo = '0; e.lat = 1; e.k = 0;
      case (op[3:2])
         2'b00: begin
            x = longint'(a) & mn;
            if (ca) x = (-x) & mn;
            y = longint'(b) & mn;
            if (cb) y = (-y) & mn;
            p = (x * y) & m2;
            if (co) p = (-p) & m2;
            e.hi = p[31:16];
            e.lo = p[15:0];
            e.lat = int'(n) + 1;
         end
         2'b01: begin
            x = (n == 16) ? longint'({d, a}) : longint'(a);
            if (ca) x = (-x) & m2;
            y = longint'(b) & mn;
            if (cb) y = (-y) & mn;
            if (y == 0 || (x >> n) >= y) begin
               e.err = 1'b1;
            end else begin
               e.lat = int'(n) + 1;
               q = x / y;
               r = x % y;
               qs = co ? -q : q;
               if (op[1] && (qs < -(longint'(1) << (n - 1)) ||
                             qs > (longint'(1) << (n - 1)) - 1)) begin
                  e.err = 1'b1;
               end else begin
                  p = co ? ((-q) & mn) : q;
                  e.lo = p[15:0];
                  p = ca ? ((-r) & mn) : r;
                  e.hi = p[15:0];
               end
            end
         end
         2'b10: begin
            x = longint'(a);
            if (ca) x = (-x) & 64'hFFFF;
            e.lo = x[15:0];
         end
         default: e.err = 1'b1;
      endcase
      return e;
   endfunction

   task automatic issue(input string nm, input logic [3:0] op,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] d, input logic ca,
                        input logic cb, input logic co);
      exp_t e;
      int   t;
      t = 0;
      while (bus.busy && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk({nm, "_idle_wait"}, {31'b0, bus.busy}, 32'd0);
      e = model(nm, op, a, b, d, ca, cb, co);
      e.k = cyc + 1;
      bus.op = op; bus.a = a; bus.b = b; bus.d = d;
      bus.c2inA = ca; bus.c2inB = cb; bus.c2out = co;
      bus.start = 1'b1;
      sbq.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((sbq.size() != 0 || bus.busy) && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("drain", sbq.size(), 32'd0);
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         done_cnt++;
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_done got hi=%h lo=%h want no done",
                     bus.res_hi, bus.res_lo);
         end else begin
            mon_e = sbq.pop_front();
            chk({mon_e.nm, "_lat"}, cyc - mon_e.k, mon_e.lat);
            chk({mon_e.nm, "_err"}, {31'b0, bus.err}, {31'b0, mon_e.err});
            chk({mon_e.nm, "_hi"}, {16'b0, bus.res_hi}, {16'b0, mon_e.hi});
            chk({mon_e.nm, "_lo"}, {16'b0, bus.res_lo}, {16'b0, mon_e.lo});
         end
      end
   end

   initial begin
      int          d0;
      logic [3:0]  op;
      logic [15:0] a, b, d;
      int          r;

      rst_n = 1'b0;
      bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.d = '0;
      bus.c2inA = 1'b0; bus.c2inB = 1'b0; bus.c2out = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'b0, bus.busy}, 32'd0);
      chk("rst_done", {31'b0, bus.done}, 32'd0);
      chk("rst_err", {31'b0, bus.err}, 32'd0);
      chk("rst_hi", {16'b0, bus.res_hi}, 32'd0);
      chk("rst_lo", {16'b0, bus.res_lo}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      issue("mul8", 4'b0000, 16'h00FF, 16'h00FF, 16'h0, 0, 0, 0);
      issue("mul16s", 4'b0011, 16'hFFFE, 16'h0003, 16'h0, 1, 0, 1);
      issue("div16", 4'b0101, 16'h0000, 16'h0003, 16'h0001, 0, 0, 0);
      issue("div8s", 4'b0110, 16'hFFF9, 16'h0002, 16'h0, 1, 0, 1);
      issue("div0", 4'b0100, 16'h1234, 16'h0000, 16'h0, 0, 0, 0);
      issue("divovf", 4'b0100, 16'h0200, 16'h0001, 16'h0, 0, 0, 0);
      issue("illegal", 4'b1100, 16'h1111, 16'h2222, 16'h0, 0, 0, 0);
      issue("neg", 4'b1000, 16'h0005, 16'h0000, 16'h0, 1, 0, 0);
      issue("sovf8", 4'b0110, 16'h0080, 16'h0001, 16'h0, 0, 0, 0);
      issue("smin8", 4'b0110, 16'h0080, 16'h0001, 16'h0, 0, 0, 1);
      drain();

      issue("mul16_busy", 4'b0001, 16'h1234, 16'h5678, 16'h0, 0, 0, 0);
      d0 = done_cnt;
      repeat (2) @(negedge clk);
      bus.op = 4'b1000; bus.a = 16'h0007; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      drain();
      repeat (3) @(negedge clk);
      chk("one_done", done_cnt - d0, 32'd1);

      issue("mul16_rst", 4'b0001, 16'hABCD, 16'h1234, 16'h0, 0, 0, 0);
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'b0, bus.busy}, 32'd0);
      chk("abort_done", {31'b0, bus.done}, 32'd0);
      chk("abort_err", {31'b0, bus.err}, 32'd0);
      chk("abort_hi", {16'b0, bus.res_hi}, 32'd0);
      chk("abort_lo", {16'b0, bus.res_lo}, 32'd0);
      sbq.delete();
      d0 = done_cnt;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      chk("no_done_after_abort", done_cnt - d0, 32'd0);

      issue("fresh", 4'b0011, 16'h8001, 16'h7FFF, 16'h0, 0, 1, 0);
      drain();

      for (int i = 0; i < 150; i++) begin
         r = $urandom_range(0, 9);
         op[3:2] = (r < 4) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
         op[1] = 1'($urandom);
         op[0] = 1'($urandom);
         a = 16'($urandom);
         b = 16'($urandom);
         d = 16'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) a[15:8] = 8'($urandom_range(0, 3));
         issue($sformatf("rnd%0d", i), op, a, b, d, 1'($urandom),
               1'($urandom), 1'($urandom));
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
